axi_rr_arbiter: RTL

- N-master to 1-slave AXI4 arbiter between the core's memory masters (IFU, LSU, later DMA/debug) and the single downstream AXI port.
- Successor to the fixed two-master arbiter:
  - master count is parametrised;
  - fixed-priority or round-robin selection;
  - full burst support, with the grant held until RLAST;
  - ID and last-beat fields are forwarded.
- Exactly one transaction (read or write) is in flight at a time.

---
 rtl/axi_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter
//   N-master to 1-slave AXI4 arbiter. Only one transaction (read or write) is
//   in flight at a time. The granted master's channels are wired through to
//   the slave until the transaction finishes (RLAST beat or B handshake).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing forwarded; arbitrate among masters with AR/AW pending
//   RD    | granted master's AR/R wired to the slave until the RLAST beat
//   WR    | granted master's AW/W/B wired to the slave until B handshake
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   m_ar*/m_r*          per-master read channels (payloads packed, slice i)
//   m_aw*/m_w*/m_b*     per-master write channels (payloads packed, slice i)
//   s_ar*..s_b*         single slave-side AXI4 port
//   grant               one-hot of the master being served, 0 when idle
module axi_rr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RR_EN  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  // master read address
  input  logic [NUM_M-1:0]               m_arvalid,
  output logic [NUM_M-1:0]               m_arready,
  input  logic [NUM_M*ADDR_W-1:0]        m_araddr,
  input  logic [NUM_M*ID_W-1:0]          m_arid,
  input  logic [NUM_M*8-1:0]             m_arlen,
  input  logic [NUM_M*3-1:0]             m_arsize,
  input  logic [NUM_M*2-1:0]             m_arburst,
  // master read data
  output logic [NUM_M-1:0]               m_rvalid,
  input  logic [NUM_M-1:0]               m_rready,
  output logic [DATA_W-1:0]              m_rdata,
  output logic [1:0]                     m_rresp,
  output logic [ID_W-1:0]                m_rid,
  output logic                           m_rlast,
  // master write address
  input  logic [NUM_M-1:0]               m_awvalid,
  output logic [NUM_M-1:0]               m_awready,
  input  logic [NUM_M*ADDR_W-1:0]        m_awaddr,
  input  logic [NUM_M*ID_W-1:0]          m_awid,
  input  logic [NUM_M*8-1:0]             m_awlen,
  input  logic [NUM_M*3-1:0]             m_awsize,
  input  logic [NUM_M*2-1:0]             m_awburst,
  // master write data
  input  logic [NUM_M-1:0]               m_wvalid,
  output logic [NUM_M-1:0]               m_wready,
  input  logic [NUM_M*DATA_W-1:0]        m_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0]    m_wstrb,
  input  logic [NUM_M-1:0]               m_wlast,
  // master write response
  output logic [NUM_M-1:0]               m_bvalid,
  input  logic [NUM_M-1:0]               m_bready,
  output logic [1:0]                     m_bresp,
  output logic [ID_W-1:0]                m_bid,
  // slave read address
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [ADDR_W-1:0]              s_araddr,
  output logic [ID_W-1:0]                s_arid,
  output logic [7:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  output logic [1:0]                     s_arburst,
  // slave read data
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic [1:0]                     s_rresp,
  input  logic [ID_W-1:0]                s_rid,
  input  logic                           s_rlast,
  // slave write address
  output logic                           s_awvalid,
  input  logic                           s_awready,
  output logic [ADDR_W-1:0]              s_awaddr,
  output logic [ID_W-1:0]                s_awid,
  output logic [7:0]                     s_awlen,
  output logic [2:0]                     s_awsize,
  output logic [1:0]                     s_awburst,
  // slave write data
  output logic                           s_wvalid,
  input  logic                           s_wready,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [(DATA_W/8)-1:0]          s_wstrb,
  output logic                           s_wlast,
  // slave write response
  input  logic                           s_bvalid,
  output logic                           s_bready,
  input  logic [1:0]                     s_bresp,
  input  logic [ID_W-1:0]                s_bid,
  // debug
  output logic [NUM_M-1:0]               grant
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  // Address/last-data-beat completion flags: once the granted master's AR, AW
  // or final W beat has been accepted, its valid is no longer forwarded, so a
  // master already presenting its next request cannot start a second
  // transaction behind the current one.
  logic               ar_done_q, ar_done_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [NUM_M-1:0]   req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_next;

  // Per-master payload views of the packed input buses
  logic [ADDR_W-1:0]  araddr_a  [NUM_M];
  logic [ID_W-1:0]    arid_a    [NUM_M];
  logic [7:0]         arlen_a   [NUM_M];
  logic [2:0]         arsize_a  [NUM_M];
  logic [1:0]         arburst_a [NUM_M];
  logic [ADDR_W-1:0]  awaddr_a  [NUM_M];
  logic [ID_W-1:0]    awid_a    [NUM_M];
  logic [7:0]         awlen_a   [NUM_M];
  logic [2:0]         awsize_a  [NUM_M];
  logic [1:0]         awburst_a [NUM_M];
  logic [DATA_W-1:0]  wdata_a   [NUM_M];
  logic [STRB_W-1:0]  wstrb_a   [NUM_M];

  for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
    assign araddr_a[g]  = m_araddr[g*ADDR_W +: ADDR_W];
    assign arid_a[g]    = m_arid[g*ID_W +: ID_W];
    assign arlen_a[g]   = m_arlen[g*8 +: 8];
    assign arsize_a[g]  = m_arsize[g*3 +: 3];
    assign arburst_a[g] = m_arburst[g*2 +: 2];
    assign awaddr_a[g]  = m_awaddr[g*ADDR_W +: ADDR_W];
    assign awid_a[g]    = m_awid[g*ID_W +: ID_W];
    assign awlen_a[g]   = m_awlen[g*8 +: 8];
    assign awsize_a[g]  = m_awsize[g*3 +: 3];
    assign awburst_a[g] = m_awburst[g*2 +: 2];
    assign wdata_a[g]   = m_wdata[g*DATA_W +: DATA_W];
    assign wstrb_a[g]   = m_wstrb[g*STRB_W +: STRB_W];
  end

  assign req   = m_arvalid | m_awvalid;
  assign grant = grant_q;

  // Winner search: scan from ptr (round-robin) or from 0 (fixed priority),
  // wrapping modulo NUM_M; the first requester found wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = (RR_EN != 0) ? (int'(ptr_q) + k) : k;
      if (cand >= NUM_M) begin
        cand = cand - NUM_M;
      end
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_next = (win_idx == IDX_W'(NUM_M - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      gidx_q    <= '0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d   = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
          gidx_d    = win_idx;
          ptr_d     = win_next;
          ar_done_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // read-first when a master presents both
          state_d   = m_arvalid[win_idx] ? RD : WR;
        end
      end
      RD: begin
        if (s_arvalid && s_arready) begin
          ar_done_d = 1'b1;
        end
        if (s_rvalid && s_rready && s_rlast) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      WR: begin
        if (s_awvalid && s_awready) begin
          aw_done_d = 1'b1;
        end
        if (s_wvalid && s_wready && s_wlast) begin
          w_done_d = 1'b1;
        end
        if (s_bvalid && s_bready) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Channel steering uses the registered grant index only. In IDLE (and so
  // throughout reset) every output stays at 0.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rid     = '0;
    m_rlast   = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_bid     = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    case (state_q)
      RD: begin
        s_arvalid         = m_arvalid[gidx_q] & ~ar_done_q;
        s_araddr          = araddr_a[gidx_q];
        s_arid            = arid_a[gidx_q];
        s_arlen           = arlen_a[gidx_q];
        s_arsize          = arsize_a[gidx_q];
        s_arburst         = arburst_a[gidx_q];
        m_arready[gidx_q] = s_arready & ~ar_done_q;
        s_rready          = m_rready[gidx_q];
        m_rvalid[gidx_q]  = s_rvalid;
        m_rdata           = s_rdata;
        m_rresp           = s_rresp;
        m_rid             = s_rid;
        m_rlast           = s_rlast;
      end
      WR: begin
        s_awvalid         = m_awvalid[gidx_q] & ~aw_done_q;
        s_awaddr          = awaddr_a[gidx_q];
        s_awid            = awid_a[gidx_q];
        s_awlen           = awlen_a[gidx_q];
        s_awsize          = awsize_a[gidx_q];
        s_awburst         = awburst_a[gidx_q];
        m_awready[gidx_q] = s_awready & ~aw_done_q;
        s_wvalid          = m_wvalid[gidx_q] & ~w_done_q;
        s_wdata           = wdata_a[gidx_q];
        s_wstrb           = wstrb_a[gidx_q];
        s_wlast           = m_wlast[gidx_q];
        m_wready[gidx_q]  = s_wready & ~w_done_q;
        s_bready          = m_bready[gidx_q];
        m_bvalid[gidx_q]  = s_bvalid;
        m_bresp           = s_bresp;
        m_bid             = s_bid;
      end
      default: ;
    endcase
  end

endmodule
